// File: rtl/card_pkg.sv
// Shared constants, card word layout and shuffler state encoding for the memory-match card path.
package card_pkg;

    localparam int unsigned NUM_CARDS = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 6;
    localparam int unsigned VAL_W     = 4;

    localparam int unsigned CARD_REMOVED_BIT  = 5;
    localparam int unsigned CARD_FACEDOWN_BIT = 4;
    localparam logic [1:0]  CARD_FACE_DOWN    = 2'b01;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StInit    = 3'd1,
        StShuffle = 3'd2,
        StWrite   = 3'd3,
        StDone    = 3'd4
    } shuf_state_e;

endpackage

// File: rtl/card_deck_shuffler_if.sv
// Start/status handshake plus card memory port B write bus driven by the deck shuffler.
interface card_deck_shuffler_if;
    import card_pkg::*;

    logic                Start;
    logic [7:0]          seed;
    logic                Busy;
    logic                WriteEnable;
    logic [ADDR_W-1:0]   dataLoc;
    logic [DATA_W-1:0]   dataOut;
    logic                Done;

    modport master (
        input  Start, seed,
        output Busy, WriteEnable, dataLoc, dataOut, Done
    );

    modport slave (
        output Start, seed,
        input  Busy, WriteEnable, dataLoc, dataOut, Done
    );

endinterface

// File: rtl/card_lfsr.sv
// Fibonacci LFSR shifting left with XOR feedback into bit 0; load has priority over step.
module card_lfsr #(
    parameter int unsigned        LFSR_W    = 8,
    parameter logic [LFSR_W-1:0]  TAPS      = 8'hB8,
    parameter logic [LFSR_W-1:0]  RESET_VAL = 8'h01
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (step) begin
            q_d = {q_q[LFSR_W-2:0], ^(q_q & TAPS)};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_deck_shuffler.sv
// Builds 8 value pairs, Fisher-Yates shuffles them with an LFSR, then writes all 16 cards
// face-down through memory port B and pulses Done.
module card_deck_shuffler
    import card_pkg::*;
#(
    parameter int unsigned       LFSR_W        = 8,
    parameter logic [LFSR_W-1:0] ZERO_SEED_SUB = 8'h01
) (
    input  logic                 Clk,
    input  logic                 Reset,
    card_deck_shuffler_if.master bus
);

    shuf_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]   deck_q [NUM_CARDS];
    logic [VAL_W-1:0]   deck_d [NUM_CARDS];

    logic               busy_q, busy_d;
    logic               we_q, we_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  loc_q, loc_d;
    logic [DATA_W-1:0]  out_q, out_d;

    logic               lfsr_load, lfsr_step;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_load_val;
    logic [LFSR_W-ADDR_W-1:0] unused_lfsr_hi;
    logic [ADDR_W-1:0]  draw_bits, draw_val, swap_j;

    // Smallest all-ones value covering i, so the masked draw needs at most one fold.
    function automatic logic [ADDR_W-1:0] draw_mask(input logic [ADDR_W-1:0] i);
        if (i >= 4'd8)      return 4'd15;
        else if (i >= 4'd4) return 4'd7;
        else if (i >= 4'd2) return 4'd3;
        else                return 4'd1;
    endfunction

    assign lfsr_load_val = (bus.seed == '0) ? ZERO_SEED_SUB : LFSR_W'(bus.seed);

    card_lfsr #(
        .LFSR_W    (LFSR_W),
        .TAPS      (8'hB8),
        .RESET_VAL (ZERO_SEED_SUB)
    ) u_lfsr (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .step     (lfsr_step),
        .q        (lfsr_q)
    );

    assign {unused_lfsr_hi, draw_bits} = lfsr_q;
    assign draw_val = draw_bits & draw_mask(idx_q);
    assign swap_j   = (draw_val > idx_q) ? draw_val - idx_q - 4'd1 : draw_val;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge Clk) begin
        deck_q <= deck_d;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        deck_d    = deck_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d   = StInit;
                    lfsr_load = 1'b1;
                end
            end
            StInit: begin
                for (int k = 0; k < NUM_CARDS; k++) begin
                    deck_d[k] = VAL_W'(k / 2 + 1);
                end
                idx_d   = ADDR_W'(NUM_CARDS - 1);
                state_d = StShuffle;
            end
            StShuffle: begin
                lfsr_step      = 1'b1;
                deck_d[idx_q]  = deck_q[swap_j];
                deck_d[swap_j] = deck_q[idx_q];
                if (idx_q == 4'd1) begin
                    idx_d   = '0;
                    state_d = StWrite;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            StWrite: begin
                if (idx_q == ADDR_W'(NUM_CARDS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        busy_d = (state_d != StIdle);
        we_d   = (state_d == StWrite);
        done_d = (state_d == StDone);
        loc_d  = loc_q;
        out_d  = out_q;
        if (state_d == StWrite) begin
            loc_d = idx_d;
            out_d = {CARD_FACE_DOWN, deck_d[idx_d]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            loc_q  <= '0;
            out_q  <= '0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            done_q <= done_d;
            loc_q  <= loc_d;
            out_q  <= out_d;
        end
    end

    assign bus.Busy        = busy_q;
    assign bus.WriteEnable = we_q;
    assign bus.Done        = done_q;
    assign bus.dataLoc     = loc_q;
    assign bus.dataOut     = out_q;

endmodule

// File: tb/tb_card_deck_shuffler.sv
// Randomised self-checking bench for card_deck_shuffler against an array-based Fisher-Yates model.
module tb_card_deck_shuffler;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [5:0] gold [16];
    logic [5:0] cap  [16];

    card_deck_shuffler_if bus_if ();

    card_deck_shuffler dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    task automatic model_run(input logic [7:0] s);
        int l, m, d, j, t;
        int deck [16];
        l = (s == 8'h00) ? 1 : int'(s);
        for (int k = 0; k < 16; k++) deck[k] = k / 2 + 1;
        for (int i = 15; i >= 1; i--) begin
            m = 1;
            while (m < i) m = m * 2 + 1;
            d = (l & 15) & m;
            j = (d > i) ? d - i - 1 : d;
            t = deck[i]; deck[i] = deck[j]; deck[j] = t;
            l = lfsr_next(l);
        end
        for (int k = 0; k < 16; k++) gold[k] = {2'b01, 4'(deck[k])};
    endtask

    task automatic run_deck(input logic [7:0] s, input bit inject);
        int cnt [9];
        bit pairs_ok;
        model_run(s);
        @(negedge clk);
        bus_if.Start = 1'b1;
        bus_if.seed  = s;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            bus_if.Start = inject && (c == 5 || c == 20);
            if (inject) bus_if.seed = 8'($urandom);
            check_eq($sformatf("busy s%0h c%0d", s, c), 32'(bus_if.Busy), 32'(c <= 33));
            check_eq($sformatf("we s%0h c%0d", s, c), 32'(bus_if.WriteEnable),
                     32'(c >= 17 && c <= 32));
            check_eq($sformatf("done s%0h c%0d", s, c), 32'(bus_if.Done), 32'(c == 33));
            if (c >= 17 && c <= 32) begin
                check_eq($sformatf("loc s%0h c%0d", s, c), 32'(bus_if.dataLoc), 32'(c - 17));
                check_eq($sformatf("data s%0h c%0d", s, c), 32'(bus_if.dataOut),
                         32'(gold[c - 17]));
                cap[c - 17] = bus_if.dataOut;
            end
        end
        bus_if.Start = 1'b0;
        for (int v = 0; v < 9; v++) cnt[v] = 0;
        pairs_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (cap[k][5:4] != 2'b01 || cap[k][3:0] == 4'd0 || cap[k][3:0] > 4'd8) pairs_ok = 1'b0;
            else cnt[cap[k][3:0]]++;
        end
        for (int v = 1; v < 9; v++) if (cnt[v] != 2) pairs_ok = 1'b0;
        check_eq($sformatf("pairs s%0h", s), 32'(pairs_ok), 32'd1);
    endtask

    task automatic reset_mid_write(input logic [7:0] s);
        @(negedge clk);
        bus_if.Start = 1'b1;
        bus_if.seed  = s;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            bus_if.Start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid rst we", 32'(bus_if.WriteEnable), 32'd0);
        check_eq("mid rst busy", 32'(bus_if.Busy), 32'd0);
        check_eq("mid rst done", 32'(bus_if.Done), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq($sformatf("post rst idle %0d", c),
                     32'({bus_if.Done, bus_if.WriteEnable, bus_if.Busy}), 32'd0);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus_if.Start = 1'b1;
        bus_if.seed  = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("rst busy %0d", c), 32'(bus_if.Busy), 32'd0);
            check_eq($sformatf("rst we %0d", c), 32'(bus_if.WriteEnable), 32'd0);
            check_eq($sformatf("rst done %0d", c), 32'(bus_if.Done), 32'd0);
            check_eq($sformatf("rst loc %0d", c), 32'(bus_if.dataLoc), 32'd0);
            check_eq($sformatf("rst data %0d", c), 32'(bus_if.dataOut), 32'd0);
        end
        rst          = 1'b0;
        bus_if.Start = 1'b0;
        @(negedge clk);
        check_eq("idle after rst", 32'(bus_if.Busy), 32'd0);

        run_deck(8'hA5, 1'b0);
        run_deck(8'hA5, 1'b0);
        run_deck(8'h3C, 1'b0);
        run_deck(8'h00, 1'b0);
        run_deck(8'h01, 1'b0);
        run_deck(8'hA5, 1'b1);
        for (int r = 0; r < 4; r++) begin
            run_deck(8'($urandom), (r % 2) == 1);
        end
        reset_mid_write(8'h5A);
        run_deck(8'hA5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
